alu_seq: RTL and testbench

//  Parametrised, registered ALU with valid/ready handshakes on both sides; the next generation of the 4-bit combinational ALU.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_iter_muldiv.sv | 105 ++++++++++
 rtl/alu_seq.sv | 184 ++++++++++++++++++
 tb/tb_alu_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: the 16-op encoding inherited from the
// combinational ALU and the handshake FSM state encoding.
package alu_pkg;

  localparam int OPW_FIXED = 4;

  localparam logic [3:0] ADD    = 4'h0;
  localparam logic [3:0] SUB    = 4'h1;
  localparam logic [3:0] MUL    = 4'h2;
  localparam logic [3:0] DIV    = 4'h3;
  localparam logic [3:0] OR_    = 4'h4;
  localparam logic [3:0] AND_   = 4'h5;
  localparam logic [3:0] NOT_   = 4'h6;
  localparam logic [3:0] RED_OR = 4'h7;
  localparam logic [3:0] INC    = 4'h8;
  localparam logic [3:0] DEC    = 4'h9;
  localparam logic [3:0] BAND   = 4'hA;
  localparam logic [3:0] BOR    = 4'hB;
  localparam logic [3:0] BXOR   = 4'hC;
  localparam logic [3:0] BXNOR  = 4'hD;
  localparam logic [3:0] SHL    = 4'hE;
  localparam logic [3:0] SHR    = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [3:0] opc);
    return (opc == MUL) || (opc == DIV);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// Both share one {hi,lo} shift register pair so the result is simply {hi,lo}.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [OPW-1:0]     op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div0
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic [WIDTH-1:0]   opnd_r;
  logic               div_r;
  logic               div0_r;
  logic               busy_r;
  logic [CW-1:0]      cnt_r;

  logic               start_div_s;
  logic [WIDTH-1:0]   init_lo_s;
  logic [WIDTH-1:0]   init_opnd_s;
  logic [2*WIDTH-1:0] first_s;
  logic [2*WIDTH-1:0] next_s;
  logic               done_s;

  // MUL: lo holds the multiplier, hi accumulates; DIV: lo holds dividend/quotient, hi the remainder.
  function automatic logic [2*WIDTH-1:0] step(input logic [WIDTH-1:0] hi,
                                              input logic [WIDTH-1:0] lo,
                                              input logic [WIDTH-1:0] d,
                                              input logic             is_div);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH-1:0] rem;
    logic [2*WIDTH-1:0] res;
    shl = {hi, lo[WIDTH-1]};
    rem = shl[WIDTH-1:0] - d;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, d} : {(WIDTH+1){1'b0}});
    if (is_div) begin
      if (shl >= {1'b0, d}) begin
        res = {rem, lo[WIDTH-2:0], 1'b1};
      end else begin
        res = {shl[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      res = {sum, lo[WIDTH-1:1]};
    end
    return res;
  endfunction

  // Operand steering for the first step and the next-step value for running iterations.
  always_comb begin
    start_div_s = (op == DIV);
    init_lo_s   = start_div_s ? a : b;
    init_opnd_s = start_div_s ? b : a;
    first_s     = step({WIDTH{1'b0}}, init_lo_s, init_opnd_s, start_div_s);
    next_s      = step(hi_r, lo_r, opnd_r, div_r);
  end

  assign done_s = busy_r && (cnt_r == CW'(WIDTH));

  // Iteration registers: the first step is folded into the load so WIDTH steps end WIDTH-1 edges later.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
      opnd_r <= {WIDTH{1'b0}};
      div_r  <= 1'b0;
      div0_r <= 1'b0;
      busy_r <= 1'b0;
      cnt_r  <= {CW{1'b0}};
    end else if (start) begin
      {hi_r, lo_r} <= first_s;
      opnd_r       <= init_opnd_s;
      div_r        <= start_div_s;
      div0_r       <= start_div_s && (b == {WIDTH{1'b0}});
      busy_r       <= 1'b1;
      cnt_r        <= CW'(1);
    end else if (busy_r) begin
      if (done_s) begin
        busy_r <= 1'b0;
      end else begin
        {hi_r, lo_r} <= next_s;
        cnt_r        <= cnt_r + CW'(1);
      end
    end else begin
      busy_r <= 1'b0;
    end
  end

  assign done   = done_s;
  assign result = {hi_r, lo_r};
  assign div0   = div0_r;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides: single-cycle ops finish on the accept
// edge, MUL/DIV go through the iterative unit; one operation in flight at a time.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [OPW-1:0]     op,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               carry,
  output logic               zero,
  output logic               div0
);

  state_t             state_r;
  logic               in_ready_r;
  logic [2*WIDTH-1:0] out_r;
  logic               out_valid_r;
  logic               carry_r;
  logic               zero_r;
  logic               div0_r;

  logic               accept_s;
  logic               md_start_s;
  logic               md_done_s;
  logic [2*WIDTH-1:0] md_result_s;
  logic               md_div0_s;
  logic [WIDTH:0]     sc_sum_s;
  logic [2*WIDTH-1:0] sc_res_s;
  logic               sc_carry_s;
  logic               sc_flag_s;

  assign accept_s   = in_valid && in_ready_r;
  assign md_start_s = accept_s && is_muldiv(op);

  alu_iter_muldiv #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start_s),
    .op     (op),
    .a      (a),
    .b      (b),
    .done   (md_done_s),
    .result (md_result_s),
    .div0   (md_div0_s)
  );

  // Single-cycle datapath; WIDTH+1-bit results carry the carry/borrow in their top bit.
  always_comb begin
    sc_sum_s   = {(WIDTH+1){1'b0}};
    sc_flag_s  = 1'b0;
    sc_res_s   = {(2*WIDTH){1'b0}};
    sc_carry_s = 1'b0;
    case (op)
      ADD: begin
        sc_sum_s   = {1'b0, a} + {1'b0, b};
        sc_carry_s = sc_sum_s[WIDTH];
        sc_res_s   = {{(WIDTH-1){1'b0}}, sc_sum_s};
      end
      SUB: begin
        sc_sum_s   = {1'b0, a} - {1'b0, b};
        sc_carry_s = sc_sum_s[WIDTH];
        sc_res_s   = {{(WIDTH-1){1'b0}}, sc_sum_s};
      end
      INC: begin
        sc_sum_s   = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
        sc_carry_s = sc_sum_s[WIDTH];
        sc_res_s   = {{(WIDTH-1){1'b0}}, sc_sum_s};
      end
      DEC: begin
        sc_sum_s   = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};
        sc_carry_s = sc_sum_s[WIDTH];
        sc_res_s   = {{(WIDTH-1){1'b0}}, sc_sum_s};
      end
      SHL: begin
        sc_sum_s   = {a, 1'b0};
        sc_carry_s = sc_sum_s[WIDTH];
        sc_res_s   = {{(WIDTH-1){1'b0}}, sc_sum_s};
      end
      SHR: begin
        sc_res_s = {{(WIDTH+1){1'b0}}, a[WIDTH-1:1]};
      end
      OR_: begin
        sc_flag_s = (a != {WIDTH{1'b0}}) || (b != {WIDTH{1'b0}});
        sc_res_s  = {{(2*WIDTH-1){1'b0}}, sc_flag_s};
      end
      AND_: begin
        sc_flag_s = (a != {WIDTH{1'b0}}) && (b != {WIDTH{1'b0}});
        sc_res_s  = {{(2*WIDTH-1){1'b0}}, sc_flag_s};
      end
      NOT_: begin
        sc_flag_s = (a == {WIDTH{1'b0}});
        sc_res_s  = {{(2*WIDTH-1){1'b0}}, sc_flag_s};
      end
      RED_OR: begin
        sc_flag_s = |a;
        sc_res_s  = {{(2*WIDTH-1){1'b0}}, sc_flag_s};
      end
      BAND:    sc_res_s = {{WIDTH{1'b0}}, a & b};
      BOR:     sc_res_s = {{WIDTH{1'b0}}, a | b};
      BXOR:    sc_res_s = {{WIDTH{1'b0}}, a ^ b};
      BXNOR:   sc_res_s = {{WIDTH{1'b0}}, ~(a ^ b)};
      default: sc_res_s = {(2*WIDTH){1'b0}};
    endcase
  end

  // Handshake FSM with registered result/flags; out is held through back-pressure in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_r       <= {(2*WIDTH){1'b0}};
      out_valid_r <= 1'b0;
      carry_r     <= 1'b0;
      zero_r      <= 1'b0;
      div0_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && is_muldiv(op)) begin
            state_r    <= BUSY;
            in_ready_r <= 1'b0;
          end else if (accept_s) begin
            state_r     <= DONE;
            in_ready_r  <= 1'b0;
            out_r       <= sc_res_s;
            out_valid_r <= 1'b1;
            carry_r     <= sc_carry_s;
            zero_r      <= (sc_res_s == {(2*WIDTH){1'b0}});
            div0_r      <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (md_done_s) begin
            state_r     <= DONE;
            out_r       <= md_result_s;
            out_valid_r <= 1'b1;
            carry_r     <= 1'b0;
            zero_r      <= (md_result_s == {(2*WIDTH){1'b0}});
            div0_r      <= md_div0_s;
          end else begin
            state_r <= BUSY;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out       = out_r;
  assign out_valid = out_valid_r;
  assign carry     = carry_r;
  assign zero      = zero_r;
  assign div0      = div0_r;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): the driver pushes hand-computed results,
// an independent monitor pops and compares on every output transfer.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  typedef struct {
    string       name;
    logic [15:0] out;
    logic        carry;
    logic        zero;
    logic        div0;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [3:0]    op = 4'h0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2*W-1:0] out;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          carry;
  logic          zero;
  logic          div0;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  alu_seq #(.WIDTH(W), .OPW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .carry     (carry),
    .zero      (zero),
    .div0      (div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Issue one op, push its expectation, and check result latency and in_ready while waiting.
  task automatic send(input string name, input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv,
                      input logic [15:0] eo, input logic ec, input logic ez, input logic ed, input int lat_req);
    exp_t e;
    bit   ok = 0;
    bit   got = 0;
    int   lat = 0;
    int   bad_ready = 0;
    op = o; a = av; b = bv; in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_accept: got in_ready=0 for 40 cycles, required 1", name);
      in_valid = 1'b0;
      return;
    end
    e.name = name; e.out = eo; e.carry = ec; e.zero = ez; e.div0 = ed;
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid === 1'b1) got = 1;
      else if (in_ready !== 1'b0) bad_ready++;
    end
    check({name, "_latency"}, got ? lat : -1, lat_req);
    check({name, "_in_ready_low"}, bad_ready, 0);
    @(posedge clk); #1;
  endtask

  // Monitor: every out_valid && out_ready transfer must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got out=%h, required no transfer", out);
        end else begin
          mon_e = sb_q.pop_front();
          if (out !== mon_e.out || carry !== mon_e.carry || zero !== mon_e.zero || div0 !== mon_e.div0) begin
            errors++;
            $display("FAIL %s: got out=%h c=%b z=%b d0=%b, required out=%h c=%b z=%b d0=%b",
                     mon_e.name, out, carry, zero, div0, mon_e.out, mon_e.carry, mon_e.zero, mon_e.div0);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of stimulus, required finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    bit saw_valid;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out", out, 16'h0000);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_flags", {carry, zero, div0}, 3'b000);
    check("reset_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    send("add_ff_01",   ADD,   8'hFF, 8'h01, 16'h0100, 1'b1, 1'b0, 1'b0, 1);
    send("mul_ff_ff",   MUL,   8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 1'b0, 9);
    send("mul_0c_0a",   MUL,   8'h0C, 8'h0A, 16'h0078, 1'b0, 1'b0, 1'b0, 9);
    send("mul_zero",    MUL,   8'h00, 8'h05, 16'h0000, 1'b0, 1'b1, 1'b0, 9);
    send("div_100_7",   DIV,   8'd100, 8'd7, 16'h020E, 1'b0, 1'b0, 1'b0, 9);
    send("div_100_0",   DIV,   8'd100, 8'd0, 16'h64FF, 1'b0, 1'b0, 1'b1, 9);
    send("div_ff_10",   DIV,   8'hFF, 8'h10, 16'h0F0F, 1'b0, 1'b0, 1'b0, 9);

    // SUB held under back-pressure while the next op is already presented.
    out_ready = 1'b0;
    send("sub_3_5",     SUB,   8'h03, 8'h05, 16'h01FE, 1'b1, 1'b0, 1'b0, 1);
    op = INC; a = 8'h7F; b = 8'h00; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold", {out_valid, carry, in_ready, out}, {1'b1, 1'b1, 1'b0, 16'h01FE});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("done_no_accept", {out_valid, in_ready}, 2'b10);
    @(posedge clk); #1;
    send("inc_7f",      INC,   8'h7F, 8'h00, 16'h0080, 1'b0, 1'b0, 1'b0, 1);

    send("dec_00",      DEC,   8'h00, 8'h00, 16'h01FF, 1'b1, 1'b0, 1'b0, 1);
    send("shl_81",      SHL,   8'h81, 8'h00, 16'h0102, 1'b1, 1'b0, 1'b0, 1);
    send("or_0_0",      OR_,   8'h00, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1);
    send("and_3_0",     AND_,  8'h03, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1);
    send("not_0",       NOT_,  8'h00, 8'h00, 16'h0001, 1'b0, 1'b0, 1'b0, 1);
    send("red_or_10",   RED_OR,8'h10, 8'h00, 16'h0001, 1'b0, 1'b0, 1'b0, 1);
    send("band",        BAND,  8'hF3, 8'h3C, 16'h0030, 1'b0, 1'b0, 1'b0, 1);
    send("bor",         BOR,   8'hA0, 8'h05, 16'h00A5, 1'b0, 1'b0, 1'b0, 1);
    send("bxor",        BXOR,  8'hAA, 8'h0F, 16'h00A5, 1'b0, 1'b0, 1'b0, 1);
    send("shr_81",      SHR,   8'h81, 8'h00, 16'h0040, 1'b0, 1'b0, 1'b0, 1);
    send("bxnor_f0_0f", BXNOR, 8'hF0, 8'h0F, 16'h0000, 1'b0, 1'b1, 1'b0, 1);

    // Reset three cycles into a DIV: the op must vanish without a result.
    op = DIV; a = 8'd100; b = 8'd7; in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midreset_state", {out_valid, in_ready, out}, {1'b0, 1'b1, 16'h0000});
    saw_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) saw_valid = 1;
    end
    check("midreset_no_valid", saw_valid, 1'b0);
    @(posedge clk); #1;
    send("add_after_rst", ADD, 8'h02, 8'h03, 16'h0005, 1'b0, 1'b0, 1'b0, 1);

    repeat (4) @(posedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
